// File: rtl/md_unit_pkg.sv
// md_unit_pkg: constants shared by the multiply/divide unit and its users.
//   - md_op operation codes (4 bits)
//   - FSM state encoding for md_unit
//   - helpers that classify an md_op as mult-class or div-class
// Optional feature macro: MDU_MADD_EN (accept MADD/MADDU/MSUB/MSUBU as mult-class).
package md_unit_pkg;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
   localparam logic [3:0] MD_MADD  = 4'd7;
   localparam logic [3:0] MD_MADDU = 4'd8;
   localparam logic [3:0] MD_MSUB  = 4'd9;
   localparam logic [3:0] MD_MSUBU = 4'd10;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   // Mult-class ops take MULT_CYCLES; the accumulate family only joins
   // the class when the feature is built in, otherwise it acts like MD_NONE.
   function automatic logic is_mult_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
             (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
      return (op == MD_MULT) || (op == MD_MULTU);
`endif
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage request / HI-LO result bundle of the multiply/divide unit.
//   start, md_op, src_a, src_b : driven by the pipeline (master)
//   busy, hi, lo               : driven by md_unit (slave)
interface md_unit_if;

   logic        start;
   logic [3:0]  md_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, md_op, src_a, src_b,
                   input  busy, hi, lo);

   modport slave  (input  start, md_op, src_a, src_b,
                   output busy, hi, lo);

endinterface

// File: rtl/md_unit_arith.sv
// md_arith: purely combinational datapath of the multiply/divide unit.
//   op       : md_op code
//   a, b     : rs / rt operands
//   hi, lo   : current committed HI/LO (accumulator for MADD/MSUB family)
//   result   : {HI, LO} value to be committed later
//   div_zero : divisor is zero (result must not be written)
// The accumulate results are always computed here; whether those codes are
// accepted is decided in md_unit (macro MDU_MADD_EN).
module md_arith
   import md_unit_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [63:0] result,
   output logic        div_zero
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_safe;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] q_s;
   logic [31:0] r_s;

   // Products are formed on sign/zero-extended 64-bit operands so the low 64
   // bits are exact for both signednesses.  Signed division works on
   // magnitudes and re-applies signs, which keeps 0x80000000 / -1 well
   // defined (quotient wraps to 0x80000000, remainder 0).  A zero divisor is
   // replaced by 1 to keep the divider defined; that result is never committed.
   always_comb begin
      prod_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u   = {32'd0, a} * {32'd0, b};
      div_zero = (b == 32'd0);
      a_mag    = a[31] ? (32'd0 - a) : a;
      b_mag    = b[31] ? (32'd0 - b) : b;
      b_safe   = div_zero ? 32'd1 : b_mag;
      q_mag    = a_mag / b_safe;
      r_mag    = a_mag % b_safe;
      q_s      = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
      r_s      = a[31] ? (32'd0 - r_mag) : r_mag;
      result   = 64'd0;
      unique case (op)
         MD_MULT:  result = prod_s;
         MD_MULTU: result = prod_u;
         MD_DIV:   result = {r_s, q_s};
         MD_DIVU:  result = div_zero ? 64'd0 : {a % b_safe, a / b_safe};
         MD_MADD:  result = {hi, lo} + prod_s;
         MD_MADDU: result = {hi, lo} + prod_u;
         MD_MSUB:  result = {hi, lo} - prod_s;
         MD_MSUBU: result = {hi, lo} - prod_u;
         default:  result = 64'd0;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding architectural HI/LO.
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset, clears all state
//   md     : md_unit_if.slave
//            start/md_op/src_a/src_b in, busy/hi/lo out
// The result is computed at the start edge and held in pend until the
// fixed latency expires, then committed.  hi/lo show committed values only.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU accepted).
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic     clk,
   input  logic     reset,
   md_unit_if.slave md
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      pend_q, pend_d;
   logic             nowrite_q, nowrite_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [63:0]      arith_result;
   logic             arith_div_zero;

   md_arith u_arith (
      .op       (md.md_op),
      .a        (md.src_a),
      .b        (md.src_b),
      .hi       (hi_q),
      .lo       (lo_q),
      .result   (arith_result),
      .div_zero (arith_div_zero)
   );

   // All state registers; reset may arrive mid-operation and drops
   // everything, including the pending result, immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= MD_IDLE;
         cnt_q     <= '0;
         pend_q    <= 64'd0;
         nowrite_q <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         nowrite_q <= nowrite_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Next-state logic.  In IDLE a start either launches a timed operation
   // or performs an immediate MTHI/MTLO write.  In RUN the counter runs down
   // and start is ignored; the commit happens on the edge where cnt is 1 so
   // new HI/LO appear in the same cycle busy falls.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      nowrite_d = nowrite_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      unique case (state_q)
         MD_IDLE: begin
            if (md.start) begin
               if (is_mult_op(md.md_op)) begin
                  pend_d    = arith_result;
                  nowrite_d = 1'b0;
                  cnt_d     = CNT_W'(MULT_CYCLES);
                  state_d   = MD_RUN;
               end else if (is_div_op(md.md_op)) begin
                  pend_d    = arith_result;
                  nowrite_d = arith_div_zero;
                  cnt_d     = CNT_W'(DIV_CYCLES);
                  state_d   = MD_RUN;
               end else if (md.md_op == MD_MTHI) begin
                  hi_d = md.src_a;
               end else if (md.md_op == MD_MTLO) begin
                  lo_d = md.src_a;
               end
            end
         end
         MD_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = MD_IDLE;
               if (!nowrite_q) begin
                  hi_d = pend_q[63:32];
                  lo_d = pend_q[31:0];
               end
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   // Outputs come straight from registers.
   always_comb begin
      md.busy = (state_q == MD_RUN);
      md.hi   = hi_q;
      md.lo   = lo_q;
   end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed, table-driven bench for md_unit.
// A vector table holds {op, a, b, expected busy length, expected hi/lo};
// multi-cycle corner cases (div by zero, async reset mid-run, start while
// busy, accumulate ops when MDU_MADD_EN is defined) are hand-written.
module tb_md_unit;
   import md_unit_pkg::*;

   localparam int BUSY_LIMIT = 50;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          exp_cycles;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   int   cycles;
   vec_t vecs[$];
   logic [31:0] prev_hi;
   logic [31:0] prev_lo;

   md_unit_if md_bus ();

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (md_bus.slave)
   );

   // Free-running 10 time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison; every call counts.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Presents one start pulse, returns #1 after the edge that samples it.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b);
      @(negedge clk);
      md_bus.start = 1'b1;
      md_bus.md_op = op;
      md_bus.src_a = a;
      md_bus.src_b = b;
      @(posedge clk);
      #1;
      md_bus.start = 1'b0;
      md_bus.md_op = MD_NONE;
   endtask

   // Counts busy cycles until busy falls (bounded); leaves time #1 after
   // the edge on which busy dropped.
   task automatic countBusy(output int n);
      n = 0;
      while (md_bus.busy && n < BUSY_LIMIT) begin
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      md_bus.start = 1'b0;
      md_bus.md_op = MD_NONE;
      md_bus.src_a = 32'd0;
      md_bus.src_b = 32'd0;

      vecs.push_back('{"mult_neg",   MD_MULT,  32'hFFFFFFFF, 32'd2,        5,  32'hFFFFFFFF, 32'hFFFFFFFE});
      vecs.push_back('{"multu",      MD_MULTU, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE});
      vecs.push_back('{"div_neg",    MD_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD});
      vecs.push_back('{"divu",       MD_DIVU,  32'd7,        32'd2,        10, 32'h00000001, 32'h00000003});
      vecs.push_back('{"div_ovf",    MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000});
      vecs.push_back('{"div_negb",   MD_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD});
      vecs.push_back('{"mult_2p32",  MD_MULT,  32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000});
      vecs.push_back('{"mthi",       MD_MTHI,  32'hDEAD0001, 32'd9,        0,  32'hDEAD0001, 32'h00000000});
      vecs.push_back('{"mtlo",       MD_MTLO,  32'h0000BEEF, 32'd9,        0,  32'hDEAD0001, 32'h0000BEEF});
      vecs.push_back('{"none",       MD_NONE,  32'h11111111, 32'd3,        0,  32'hDEAD0001, 32'h0000BEEF});
      vecs.push_back('{"unknown",    4'd15,    32'h22222222, 32'd3,        0,  32'hDEAD0001, 32'h0000BEEF});
`ifndef MDU_MADD_EN
      vecs.push_back('{"maddu_off",  MD_MADDU, 32'd3,        32'd4,        0,  32'hDEAD0001, 32'h0000BEEF});
`endif

      // Reset state.
      #12;
      checkOutput("reset_busy", {31'd0, md_bus.busy}, 32'd0);
      checkOutput("reset_hi", md_bus.hi, 32'd0);
      checkOutput("reset_lo", md_bus.lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Table-driven vectors; HI/LO must hold their old values while busy.
      prev_hi = 32'd0;
      prev_lo = 32'd0;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
         if (vecs[i].exp_cycles > 0) begin
            checkOutput({vecs[i].name, "_hold_hi"}, md_bus.hi, prev_hi);
            checkOutput({vecs[i].name, "_hold_lo"}, md_bus.lo, prev_lo);
         end
         countBusy(cycles);
         checkOutput({vecs[i].name, "_busy_cycles"}, 32'(cycles), 32'(vecs[i].exp_cycles));
         checkOutput({vecs[i].name, "_hi"}, md_bus.hi, vecs[i].exp_hi);
         checkOutput({vecs[i].name, "_lo"}, md_bus.lo, vecs[i].exp_lo);
         prev_hi = vecs[i].exp_hi;
         prev_lo = vecs[i].exp_lo;
      end

      // Divide by zero after MTHI/MTLO: moves land at once, division keeps
      // its full latency but leaves HI/LO untouched.
      applyStimulus(MD_MTHI, 32'h00001234, 32'd0);
      checkOutput("mthi_now_hi", md_bus.hi, 32'h00001234);
      checkOutput("mthi_now_busy", {31'd0, md_bus.busy}, 32'd0);
      applyStimulus(MD_MTLO, 32'h00005678, 32'd0);
      checkOutput("mtlo_now_lo", md_bus.lo, 32'h00005678);
      applyStimulus(MD_DIV, 32'd100, 32'd0);
      countBusy(cycles);
      checkOutput("divzero_busy_cycles", 32'(cycles), 32'd10);
      checkOutput("divzero_hi", md_bus.hi, 32'h00001234);
      checkOutput("divzero_lo", md_bus.lo, 32'h00005678);

      // Asynchronous reset in the fourth busy cycle clears everything
      // without waiting for a clock edge.
      applyStimulus(MD_DIVU, 32'd50, 32'd3);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midreset_busy", {31'd0, md_bus.busy}, 32'd0);
      checkOutput("midreset_hi", md_bus.hi, 32'd0);
      checkOutput("midreset_lo", md_bus.lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      checkOutput("postreset_hi", md_bus.hi, 32'd0);
      checkOutput("postreset_lo", md_bus.lo, 32'd0);

      // A second start during RUN is ignored: latency counts from the first
      // start and the first result (3*4) is committed.
      applyStimulus(MD_MULT, 32'd3, 32'd4);
      cycles = 0;
      while (md_bus.busy && cycles < BUSY_LIMIT) begin
         cycles++;
         if (cycles == 2) begin
            md_bus.start = 1'b1;
            md_bus.md_op = MD_DIV;
            md_bus.src_a = 32'd100;
            md_bus.src_b = 32'd7;
         end
         @(posedge clk);
         #1;
         md_bus.start = 1'b0;
         md_bus.md_op = MD_NONE;
      end
      checkOutput("restart_busy_cycles", 32'(cycles), 32'd5);
      checkOutput("restart_hi", md_bus.hi, 32'd0);
      checkOutput("restart_lo", md_bus.lo, 32'd12);
      repeat (12) @(posedge clk);
      #1;
      checkOutput("restart_late_lo", md_bus.lo, 32'd12);

`ifdef MDU_MADD_EN
      // Accumulate family: {hi,lo} sampled at the start edge.
      applyStimulus(MD_MTHI, 32'd0, 32'd0);
      applyStimulus(MD_MTLO, 32'd5, 32'd0);
      applyStimulus(MD_MADDU, 32'd3, 32'd4);
      countBusy(cycles);
      checkOutput("maddu_busy_cycles", 32'(cycles), 32'd5);
      checkOutput("maddu_hi", md_bus.hi, 32'd0);
      checkOutput("maddu_lo", md_bus.lo, 32'd17);
      applyStimulus(MD_MSUB, 32'hFFFFFFFF, 32'd20);
      countBusy(cycles);
      checkOutput("msub_hi", md_bus.hi, 32'd0);
      checkOutput("msub_lo", md_bus.lo, 32'd37);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
